// File: rtl/seq_ram_loader_pkg.sv
// Shared types and constants for the sequencer RAM loader.
package seq_ram_loader_pkg;
  localparam int         BYTES_PER_WORD = 4;
  localparam int         DATA_W         = 32;
  localparam logic [3:0] BE_ALL         = 4'hF;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    WRITE,
    VERIFY,
    DRAIN,
    FIN
  } state_t;
endpackage

// File: rtl/seq_ram_byte_packer.sv
// Little-endian byte-to-word assembler; word_valid flags the beat that completes a word.
module seq_ram_byte_packer
  import seq_ram_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              beat,
  input  logic [7:0]        octet,
  output logic              word_valid,
  output logic [DATA_W-1:0] word
);
  localparam logic [1:0] LAST_LANE = 2'(BYTES_PER_WORD - 1);

  logic [1:0] byte_cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      byte_cnt <= '0;
      word     <= '0;
    end else if (beat) begin
      word[{byte_cnt, 3'b000} +: 8] <= octet;
      byte_cnt                      <= byte_cnt + 2'd1;
    end
  end

  assign word_valid = beat && (byte_cnt == LAST_LANE);
endmodule

// File: rtl/seq_ram_loader.sv
// Avalon-MM master loading the sequencer RAM from a byte stream.
// Read-back verification is built only when SEQ_RAM_LOADER_READBACK_EN is defined.
module seq_ram_loader
  import seq_ram_loader_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int DEPTH  = 512
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_chipselect,
  output logic              avm_write,
  output logic [3:0]        avm_byteenable,
  output logic [DATA_W-1:0] avm_writedata,
  output logic              avm_clken,
  input  logic [DATA_W-1:0] avm_readdata,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [DATA_W-1:0] checksum
);
  localparam logic [ADDR_W:0] DEPTH_N = (ADDR_W + 1)'(DEPTH);

  state_t              state, state_nxt;
  logic [ADDR_W:0]     n;
  logic [ADDR_W-1:0]   addr;
  logic                last_addr;
  logic                word_valid;
  logic [DATA_W-1:0]   word;

  seq_ram_byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (state == IDLE && start),
    .beat       (s_valid && s_ready),
    .octet      (s_data),
    .word_valid (word_valid),
    .word       (word)
  );

  assign last_addr      = ({1'b0, addr} == n - 1'b1);
  assign avm_address    = addr;
  assign avm_writedata  = word;
  assign avm_byteenable = BE_ALL;
  assign avm_clken      = 1'b1;

  always_comb begin
    state_nxt      = state;
    s_ready        = 1'b0;
    avm_chipselect = 1'b0;
    avm_write      = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = (word_count == '0) ? FIN : FILL;
      FILL: begin
        s_ready = 1'b1;
        if (word_valid) state_nxt = WRITE;
      end
      WRITE: begin
        avm_chipselect = 1'b1;
        avm_write      = 1'b1;
`ifdef SEQ_RAM_LOADER_READBACK_EN
        state_nxt      = last_addr ? VERIFY : FILL;
`else
        state_nxt      = last_addr ? FIN : FILL;
`endif
      end
`ifdef SEQ_RAM_LOADER_READBACK_EN
      VERIFY: begin
        avm_chipselect = 1'b1;
        if (last_addr) state_nxt = DRAIN;
      end
      DRAIN: state_nxt = FIN;
`endif
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef SEQ_RAM_LOADER_READBACK_EN
  // rd_vld marks the cycle in which readdata belongs to a read issued last cycle.
  logic              rd_vld;
  logic [DATA_W-1:0] vsum;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_vld <= 1'b0;
      vsum   <= '0;
    end else begin
      rd_vld <= (state == VERIFY);
      if (state == IDLE && start) vsum <= '0;
      else if (rd_vld)            vsum <= vsum + avm_readdata;
    end
  end

  wire verify_ok = (vsum == checksum);
`else
  wire verify_ok = 1'b1;
  logic unused_readdata;
  assign unused_readdata = ^avm_readdata;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      n        <= '0;
      addr     <= '0;
      checksum <= '0;
      pass     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      case (state)
        IDLE: if (start) begin
          n        <= (word_count > DEPTH_N) ? DEPTH_N : word_count;
          addr     <= '0;
          checksum <= '0;
          pass     <= 1'b0;
          busy     <= 1'b1;
        end
        WRITE: begin
          checksum <= checksum + word;
          addr     <= last_addr ? '0 : addr + 1'b1;
        end
        VERIFY: if (!last_addr) addr <= addr + 1'b1;
        FIN: begin
          pass <= verify_ok;
          busy <= 1'b0;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_ram_loader.sv
// Table-driven bench with a write scoreboard and a behavioural 512x32 RAM.
module tb_seq_ram_loader;
  import seq_ram_loader_pkg::*;

`ifdef SEQ_RAM_LOADER_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  word_count = '0;
  logic [7:0]  s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [8:0]  avm_address;
  logic        avm_chipselect, avm_write, avm_clken;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_writedata, avm_readdata;
  logic        busy, done, pass;
  logic [31:0] checksum;

  seq_ram_loader dut (
    .clk(clk), .reset(reset), .start(start), .word_count(word_count),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .avm_address(avm_address), .avm_chipselect(avm_chipselect), .avm_write(avm_write),
    .avm_byteenable(avm_byteenable), .avm_writedata(avm_writedata), .avm_clken(avm_clken),
    .avm_readdata(avm_readdata), .busy(busy), .done(done), .pass(pass), .checksum(checksum)
  );

  always #5 clk = ~clk;

  // RAM model with an optional single-bit corruption on reads of address 3.
  logic [31:0] mem [512];
  logic        flip_en = 1'b0;
  always @(posedge clk) begin
    if (avm_chipselect && avm_write) mem[avm_address] <= avm_writedata;
    if (avm_chipselect && !avm_write)
      avm_readdata <= mem[avm_address] ^ ((flip_en && avm_address == 9'd3) ? 32'h1 : 32'h0);
  end

  typedef struct {
    logic [8:0]  addr;
    logic [31:0] data;
  } wr_t;
  wr_t exp_q[$];

  int n_vec = 0;
  int n_bad = 0;
  int rd_cnt = 0;
  int done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (avm_chipselect && avm_write) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write_addr", {23'd0, avm_address}, 32'hFFFF_FFFF);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("write_addr", {23'd0, avm_address}, {23'd0, e.addr});
          chk("write_data", avm_writedata, e.data);
        end
      end
      if (avm_chipselect && !avm_write) rd_cnt++;
      if (done) done_cnt++;
    end
  end

  // Drives one byte and returns at the negedge after it has been accepted.
  task automatic send_byte(input logic [7:0] b, input bit do_start);
    int bound;
    s_data  = b;
    s_valid = 1'b1;
    if (do_start) begin
      start      = 1'b1;
      word_count = 10'd1;
    end
    bound = 0;
    while (!s_ready && bound < 20) begin
      @(negedge clk);
      bound++;
    end
    chk("byte_accept", {31'd0, s_ready}, 32'd1);
    @(negedge clk);
    start = 1'b0;
  endtask

  typedef struct {
    int          wc;
    int          nw;
    bit          rnd;
    bit          flip;
    int          restart;
    bit          extra;
    bit          has_sum;
    logic [31:0] sum;
    bit          exp_pass;
  } vec_t;
  vec_t vecs[6];

  task automatic run_load(input vec_t v);
    int          n, bound, lat;
    logic [31:0] sum, w;
    logic [7:0]  bv;
    n        = (v.wc > 512) ? 512 : v.wc;
    sum      = '0;
    w        = '0;
    rd_cnt   = 0;
    done_cnt = 0;
    flip_en  = v.flip;
    start      = 1'b1;
    word_count = 10'(v.wc);
    @(negedge clk);
    start      = 1'b0;
    word_count = 10'd3;
    lat = 1;
    for (int wi = 0; wi < v.nw; wi++) begin
      for (int b = 0; b < 4; b++) begin
        bv = v.rnd ? 8'($urandom_range(0, 255)) : 8'(wi * 4 + b + 1);
        w[b*8 +: 8] = bv;
        if (b == 3) begin
          exp_q.push_back('{addr: 9'(wi), data: w});
          sum = sum + w;
        end
        send_byte(bv, v.restart == wi * 4 + b);
      end
    end
    s_valid = 1'b0;
    bound = 0;
    while (!done && bound < 5000) begin
      @(negedge clk);
      bound++;
    end
    lat += bound;
    chk("done_seen", {31'd0, done}, 32'd1);
    chk("pass", {31'd0, pass}, {31'd0, v.exp_pass});
    chk("checksum_model", checksum, sum);
    if (v.has_sum) chk("checksum_table", checksum, v.sum);
    chk("busy_after_done", {31'd0, busy}, 32'd0);
    if (v.wc == 0) chk("zero_count_latency", {31'd0, lat <= 2}, 32'd1);
    if (v.extra) begin
      s_valid = 1'b1;
      s_data  = 8'hAA;
      repeat (4) begin
        @(negedge clk);
        chk("ready_after_full", {31'd0, s_ready}, 32'd0);
      end
      s_valid = 1'b0;
    end
    repeat (3) @(negedge clk);
    chk("done_once", done_cnt, 32'd1);
    chk("read_count", rd_cnt, RB ? n : 0);
    chk("queue_empty", exp_q.size(), 32'd0);
    chk("pass_held", {31'd0, pass}, {31'd0, v.exp_pass});
    flip_en = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{wc: 2,   nw: 2,   rnd: 0, flip: 0, restart: -1, extra: 0, has_sum: 1, sum: 32'h0C0A0806, exp_pass: 1};
    vecs[1] = '{wc: 0,   nw: 0,   rnd: 0, flip: 0, restart: -1, extra: 0, has_sum: 1, sum: 32'h0,        exp_pass: 1};
    vecs[2] = '{wc: 600, nw: 512, rnd: 1, flip: 0, restart: -1, extra: 1, has_sum: 0, sum: 32'h0,        exp_pass: 1};
    vecs[3] = '{wc: 8,   nw: 8,   rnd: 1, flip: 1, restart: -1, extra: 0, has_sum: 0, sum: 32'h0,        exp_pass: !RB};
    vecs[4] = '{wc: 3,   nw: 3,   rnd: 1, flip: 0, restart: 6,  extra: 0, has_sum: 0, sum: 32'h0,        exp_pass: 1};
    vecs[5] = '{wc: 1,   nw: 1,   rnd: 1, flip: 0, restart: -1, extra: 0, has_sum: 0, sum: 32'h0,        exp_pass: 1};

    repeat (3) @(negedge clk);
    chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
    chk("rst_cs", {31'd0, avm_chipselect}, 32'd0);
    chk("rst_write", {31'd0, avm_write}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_pass", {31'd0, pass}, 32'd0);
    chk("rst_checksum", checksum, 32'd0);
    chk("rst_address", {23'd0, avm_address}, 32'd0);
    chk("rst_writedata", avm_writedata, 32'd0);
    chk("byteenable", {28'd0, avm_byteenable}, 32'hF);
    chk("clken", {31'd0, avm_clken}, 32'd1);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) run_load(vecs[i]);

    // Reset in the middle of word 5 of an 8-word load.
    start      = 1'b1;
    word_count = 10'd8;
    @(negedge clk);
    start = 1'b0;
    for (int wi = 0; wi < 5; wi++) begin
      logic [31:0] w;
      w = $urandom;
      exp_q.push_back('{addr: 9'(wi), data: w});
      for (int b = 0; b < 4; b++) send_byte(w[b*8 +: 8], 1'b0);
    end
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    s_valid = 1'b0;
    reset   = 1'b1;
    @(negedge clk);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_cs", {31'd0, avm_chipselect}, 32'd0);
    chk("midrst_s_ready", {31'd0, s_ready}, 32'd0);
    chk("midrst_queue", exp_q.size(), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run_load(vecs[5]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
